tx_block: RTL and testbench

UART-style serial transmitter that pairs with the team's receive block. It takes bytes from the host side and serialises each one as a frame: one start bit (0), 8 data bits LSB first, one stop bit (1). Each bit lasts a fixed number of clocks, matching the receiver's bit timing. It holds a one-byte buffer ahead of the shift register, so consecutive frames go out back-to-back with no idle gap.

---
 rtl/tx_block.sv | 139 +++++++++++++
 tb/tb_tx_block.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_block.sv
// tx_block: UART-style serial transmitter (start bit, 8 data bits LSB first, stop bit).
// A one-byte holding buffer sits ahead of the shifter so frames can go out back-to-back.
module tx_block #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       load_data,
  input  logic       error_clear,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_buffer_full,
  output logic       tx_done,
  output logic       write_error
);

  localparam int             TW       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]  BIT_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic [7:0]    buf_data;
  logic          buf_valid;
  logic          bit_wrap;
  logic          xfer;
  logic          wr_ok;
  logic          wr_drop;

  assign bit_wrap       = (bit_timer == BIT_LAST);
  // A write is taken when the buffer is empty or is being emptied on this very edge.
  assign wr_ok          = load_data && (!buf_valid || xfer);
  assign wr_drop        = load_data && buf_valid && !xfer;
  assign tx_buffer_full = buf_valid;

  // State register.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; xfer marks the edge where the buffer moves into the shifter.
  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    case (state)
      IDLE:  if (buf_valid) begin
               state_nxt = START;
               xfer      = 1'b1;
             end
      START: if (bit_wrap) state_nxt = DATA;
      DATA:  if (bit_wrap && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_wrap) begin
               if (buf_valid) begin
                 state_nxt = START;
                 xfer      = 1'b1;
               end else begin
                 state_nxt = IDLE;
               end
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding buffer: capture on accepted writes, release on transfer.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      buf_data  <= 8'h00;
      buf_valid <= 1'b0;
    end else if (wr_ok) begin
      buf_data  <= tx_data;
      buf_valid <= 1'b1;
    end else if (xfer) begin
      buf_valid <= 1'b0;
    end
  end

  // Bit timer: restarts on each new frame, free-runs modulo CLKS_PER_BIT while busy.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)                bit_timer <= '0;
    else if (xfer)            bit_timer <= '0;
    else if (state == IDLE)   bit_timer <= '0;
    else if (bit_wrap)        bit_timer <= '0;
    else                      bit_timer <= bit_timer + TW'(1);
  end

  // Shifter, bit index and the registered serial line.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      shifter    <= 8'h00;
      bit_idx    <= 3'd0;
      serial_out <= 1'b1;
    end else if (xfer) begin
      shifter    <= buf_data;
      bit_idx    <= 3'd0;
      serial_out <= 1'b0;
    end else if (bit_wrap) begin
      case (state)
        START: begin
          serial_out <= shifter[0];
          bit_idx    <= 3'd0;
        end
        DATA: begin
          if (bit_idx != 3'd7) begin
            shifter    <= shifter >> 1;
            serial_out <= shifter[1];
            bit_idx    <= bit_idx + 3'd1;
          end else begin
            serial_out <= 1'b1;
          end
        end
        default: serial_out <= 1'b1;
      endcase
    end
  end

  // Registered status: busy tracks the upcoming state, done pulses at stop-bit end.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_busy <= (state_nxt != IDLE);
      tx_done <= (state == STOP) && bit_wrap;
    end
  end

  // Sticky overrun flag; a dropped write beats a simultaneous clear.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)            write_error <= 1'b0;
    else if (wr_drop)     write_error <= 1'b1;
    else if (error_clear) write_error <= 1'b0;
  end

endmodule

// File: tb/tb_tx_block.sv
// tb_tx_block: randomized + directed bench with a time-stamped frame model and a
// serial-line decoder that pops expected frames from a scoreboard queue.
module tb_tx_block;
  localparam int C  = 10;
  localparam int FL = 10 * C;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       load_data = 1'b0;
  logic       error_clear = 1'b0;
  logic       serial_out, tx_busy, tx_buffer_full, tx_done, write_error;

  tx_block #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .load_data(load_data),
    .error_clear(error_clear), .serial_out(serial_out), .tx_busy(tx_busy),
    .tx_buffer_full(tx_buffer_full), .tx_done(tx_done), .write_error(write_error)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; the next edge is edge number cyc
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // model: frames as (start edge, byte); buffer occupancy intervals; error events
  int         fr_s[$];
  logic [7:0] fr_b[$];
  int         bl_e[$];
  int         bx_e[$];
  int         ev_e[$];
  bit         ev_v[$];
  int         last_start = -1000000;
  int         cur_xfer   = -1;
  // scoreboard of frames still to be seen on the line
  logic [7:0] exp_b[$];
  int         exp_s[$];

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", nm, act, expv, cyc - 1);
    end
  endtask

  function automatic void model_reset();
    fr_s.delete(); fr_b.delete(); bl_e.delete(); bx_e.delete();
    ev_e.delete(); ev_v.delete(); exp_b.delete(); exp_s.delete();
    last_start = -1000000;
    cur_xfer   = -1;
  endfunction

  function automatic int exp_serial(input int n);
    logic [7:0] b;
    int k;
    foreach (fr_s[i]) begin
      if (n >= fr_s[i] && n < fr_s[i] + FL) begin
        k = (n - fr_s[i]) / C;
        b = fr_b[i];
        if (k == 0) return 0;
        if (k == 9) return 1;
        return int'(b[k-1]);
      end
    end
    return 1;
  endfunction

  function automatic int exp_busy(input int n);
    foreach (fr_s[i]) if (n >= fr_s[i] && n < fr_s[i] + FL) return 1;
    return 0;
  endfunction

  function automatic int exp_done(input int n);
    foreach (fr_s[i]) if (n == fr_s[i] + FL) return 1;
    return 0;
  endfunction

  function automatic int exp_full(input int n);
    foreach (bl_e[i]) if (n >= bl_e[i] && n < bx_e[i]) return 1;
    return 0;
  endfunction

  function automatic int exp_err(input int n);
    int v;
    v = 0;
    foreach (ev_e[i]) if (ev_e[i] <= n) v = int'(ev_v[i]);
    return v;
  endfunction

  // Present inputs for the next edge, update the model, then step past that edge.
  task automatic drive(input bit ld, input logic [7:0] d, input bit clr);
    int e;
    int s;
    bit drop;
    e = cyc;
    drop = 1'b0;
    load_data = ld; tx_data = d; error_clear = clr;
    if (ld) begin
      if (cur_xfer > e) drop = 1'b1;
      else begin
        s = (e + 1 > last_start + FL) ? e + 1 : last_start + FL;
        fr_s.push_back(s); fr_b.push_back(d);
        exp_s.push_back(s); exp_b.push_back(d);
        bl_e.push_back(e); bx_e.push_back(s);
        last_start = s;
        cur_xfer   = s;
      end
    end
    if (drop)     begin ev_e.push_back(e); ev_v.push_back(1'b1); end
    else if (clr) begin ev_e.push_back(e); ev_v.push_back(1'b0); end
    @(posedge clk); #1;
    load_data = 1'b0; error_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: per-cycle status checks plus a line decoder feeding the scoreboard.
  bit         d_act = 1'b0;
  int         d_s = 0;
  logic [9:0] d_bits = '0;
  always @(negedge clk) begin
    int n, k;
    logic [7:0] eb;
    int es;
    n = cyc - 1;
    if (n_rst) begin
      d_act = 1'b0;
      chk("rst_serial", serial_out, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_full", tx_buffer_full, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_err", write_error, 0);
    end else if (cyc > 0) begin
      chk("serial", serial_out, exp_serial(n));
      chk("busy", tx_busy, exp_busy(n));
      chk("full", tx_buffer_full, exp_full(n));
      chk("done", tx_done, exp_done(n));
      chk("werr", write_error, exp_err(n));
      if (!d_act) begin
        if (serial_out == 1'b0) begin d_act = 1'b1; d_s = n; end
      end else if ((n - d_s) % C == C / 2) begin
        k = (n - d_s) / C;
        d_bits[k] = serial_out;
        if (k == 9) begin
          d_act = 1'b0;
          if (exp_b.size() == 0) chk("frame_unexpected", d_s, -1);
          else begin
            eb = exp_b.pop_front();
            es = exp_s.pop_front();
            chk("frame_byte", int'(d_bits[8:1]), int'(eb));
            chk("frame_start", d_s, es);
            chk("frame_startbit", int'(d_bits[0]), 0);
            chk("frame_stopbit", int'(d_bits[9]), 1);
          end
        end
      end else if ((n - d_s) % C == 0 && (n - d_s) / C == 0) begin
        d_bits = '0;
      end
    end
  end

  initial begin
    int w;
    #1 n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_serial", serial_out, 1);
    chk("reset_busy", tx_busy, 0);
    #2 n_rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_full", tx_buffer_full, 0);
    chk("post_reset_err", write_error, 0);

    // single byte
    drive(1'b1, 8'hA5, 1'b0);
    idle(105);

    // back-to-back 0x00 then 0xFF (second load five edges later)
    drive(1'b1, 8'h00, 1'b0);
    idle(4);
    drive(1'b1, 8'hFF, 1'b0);
    idle(205);

    // overrun, clear at +50, write coinciding with transfer at +101
    drive(1'b1, 8'h11, 1'b0);
    idle(1);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    idle(46);
    drive(1'b0, 8'h00, 1'b1);
    idle(50);
    drive(1'b1, 8'h44, 1'b0);
    idle(210);

    // reset during data bit 3 with a byte buffered
    drive(1'b1, 8'h0F, 1'b0);
    idle(2);
    drive(1'b1, 8'h55, 1'b0);
    idle(40);
    #2 n_rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_serial", serial_out, 1);
    chk("async_rst_full", tx_buffer_full, 0);
    @(posedge clk); @(posedge clk);
    #2 n_rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_busy", tx_busy, 0);
    chk("after_rst_full", tx_buffer_full, 0);
    drive(1'b1, 8'h81, 1'b0);
    idle(105);

    // randomized traffic with overruns and error clears
    repeat (2000) drive($urandom_range(0, 49) < 2, 8'($urandom), $urandom_range(0, 79) == 0);

    // drain, bounded
    w = 0;
    while (exp_b.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_left", exp_b.size(), 0);
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
